// File: rtl/sub4_serial.sv
// rtl/sub4_serial.sv - bit-serial subtractor d = a - b - bin with valid/ready in and out
module sub4_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_d;
   logic [CW-1:0]    cnt_q;
   logic             br_q;
   logic             br_d;
   logic             diff_bit;
   logic [WIDTH-1:0] d_q;
   logic             bout_q;
   logic             in_ready_q;
   logic             out_valid_q;

   // Single full-subtractor cell on the current LSBs plus the shifted result.
   always_comb begin
      diff_bit = a_q[0] ^ b_q[0] ^ br_q;
      br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      res_d    = {diff_bit, res_q[WIDTH-1:1]};
   end

   // Handshake FSM, operand/result shifting and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         br_q        <= 1'b0;
         d_q         <= '0;
         bout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  br_q       <= bin;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               br_q  <= br_d;
               res_q <= res_d;
               cnt_q <= cnt_q + 1'b1;
               // Last bit: publish the full difference and the final borrow.
               if (cnt_q == LAST) begin
                  d_q         <= res_d;
                  bout_q      <= br_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign d         = d_q;
   assign bout      = bout_q;

endmodule

// File: tb/tb_sub4_serial.sv
// tb/tb_sub4_serial.sv - self-checking bench for sub4_serial
module tb_sub4_serial;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] d;
   logic         bout;

   int total = 0;
   int bad   = 0;

   sub4_serial #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] exp_d;
      logic         exp_bout;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
      int n;
      n = 0;
      while (!in_ready && n < 30) begin
         tick();
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      a        = va;
      b        = vb;
      bin      = vbin;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 30) begin
         tick();
         lat++;
      end
   endtask

   task automatic consume;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int          lat;
      int          badcyc;
      logic [W:0]  tmp;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      logic        ebin;

      vecs[0] = '{4'd9,  4'd3,  1'b0, 4'h6, 1'b0};
      vecs[1] = '{4'd3,  4'd9,  1'b0, 4'hA, 1'b1};
      vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1};
      vecs[3] = '{4'd15, 4'd15, 1'b0, 4'h0, 1'b0};
      vecs[4] = '{4'd12, 4'd5,  1'b0, 4'h7, 1'b0};
      vecs[5] = '{4'd8,  4'd1,  1'b0, 4'h7, 1'b0};
      vecs[6] = '{4'd5,  4'd5,  1'b1, 4'hF, 1'b1};
      vecs[7] = '{4'd10, 4'd2,  1'b1, 4'h7, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      tick();
      tick();
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_d", 32'(d), 32'd0);
      chk("reset_bout", 32'(bout), 32'd0);
      rst = 1'b0;
      tick();

      // directed table
      for (int i = 0; i < 8; i++) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
         chk($sformatf("v%0d_busy", i), 32'(in_ready), 32'd0);
         wait_done(lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(W));
         chk($sformatf("v%0d_d", i), 32'(d), 32'(vecs[i].exp_d));
         chk($sformatf("v%0d_bout", i), 32'(bout), 32'(vecs[i].exp_bout));
         consume();
         chk($sformatf("v%0d_after_consume", i), {30'd0, out_valid, in_ready}, 32'b01);
      end

      // back-pressure: result held for 10 stalled cycles
      start_op(4'd12, 4'd5, 1'b0);
      wait_done(lat);
      chk("bp_latency", 32'(lat), 32'(W));
      badcyc = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!(out_valid === 1'b1 && d === 4'd7 && bout === 1'b0 && in_ready === 1'b0)) badcyc++;
      end
      chk("bp_stable_cycles_bad", 32'(badcyc), 32'd0);
      consume();
      chk("bp_release", {30'd0, out_valid, in_ready}, 32'b01);

      // busy-input immunity: in_valid stays high with random operands
      a = 4'd9; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
      tick();
      for (int i = 0; i < W; i++) begin
         a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         tick();
      end
      chk("imm_out_valid", 32'(out_valid), 32'd1);
      chk("imm_d", 32'(d), 32'd6);
      chk("imm_bout", 32'(bout), 32'd0);
      for (int i = 0; i < 2; i++) begin
         a = W'($urandom); b = W'($urandom);
         tick();
      end
      chk("imm_done_no_accept", {30'd0, out_valid, in_ready}, 32'b10);
      chk("imm_done_d_held", 32'(d), 32'd6);
      a = 4'd7; b = 4'd2; bin = 1'b0;
      consume();
      chk("imm_idle_after_consume", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("imm_second_accept", 32'(in_ready), 32'd0);
      wait_done(lat);
      chk("imm_second_latency", 32'(lat), 32'(W));
      chk("imm_second_d", 32'(d), 32'd5);
      consume();

      // reset in the middle of SHIFT
      start_op(4'd9, 4'd3, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_d", 32'(d), 32'd0);
      chk("rst_mid_bout", 32'(bout), 32'd0);
      chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
      start_op(4'd8, 4'd1, 1'b0);
      wait_done(lat);
      chk("rst_after_latency", 32'(lat), 32'(W));
      chk("rst_after_d", 32'(d), 32'd7);
      chk("rst_after_bout", 32'(bout), 32'd0);
      consume();

      // exhaustive back-to-back with random stalls
      for (int k = 0; k < 512; k++) begin
         ea   = W'(k);
         eb   = W'(k >> 4);
         ebin = 1'(k >> 8);
         tmp  = {1'b0, ea} - {1'b0, eb} - {{W{1'b0}}, ebin};
         start_op(ea, eb, ebin);
         wait_done(lat);
         for (int s = 0; s < int'($urandom_range(0, 2)); s++) tick();
         chk($sformatf("ex_%0d_%0d_%0d", ea, eb, ebin),
             {26'd0, lat[3:0], bout, out_valid} ^ {26'd0, 4'd0, 1'b0, 1'b0} ,
             {26'd0, 4'(W), tmp[W], 1'b1});
         chk($sformatf("ex_d_%0d_%0d_%0d", ea, eb, ebin), 32'(d), 32'(tmp[W-1:0]));
         consume();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sub4_serial.md
# sub4_serial

Bit-serial subtractor computing d = a − b − bin over WIDTH clock cycles with one full-subtractor cell and a registered borrow, the sequential inverse of the team's 4-bit ripple-carry adder. Operands enter through a valid/ready handshake. The result and borrow-out leave through a second valid/ready handshake. It serves the datapath wherever a subtraction can tolerate multi-cycle latency in exchange for minimal area.

## Interface
- WIDTH, default 4: operand and result width in bits; legal range 2 to 16.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  a, b and bin are valid this cycle.
- in_ready  output  1  block can accept operands; high only in state IDLE.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- bin  input  1  borrow-in.
- out_valid  output  1  d and bout hold a completed result; high only in state DONE.
- out_ready  input  1  downstream consumes the result.
- d  output  WIDTH  difference, (a − b − bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 exactly when a < b + bin.

## Operation
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, d = 0, bout = 0. The operand registers, the shift register, the bit counter and the borrow register are all cleared.
- State IDLE:
  - in_ready = 1.
  - On the edge where in_valid = 1, a and b are latched into operand shift registers, bin is latched into the borrow register, and the counter is set to 0.
  - Next state is SHIFT.
- State SHIFT:
  - in_ready = 0.
  - Each cycle processes bit i, starting at the LSB, with x = a_reg[0], y = b_reg[0], br = borrow register.
  - Difference bit: diff = x ^ y ^ br.
  - New borrow: (~x & y) | (~(x ^ y) & br).
  - diff shifts into the result register from the MSB side. The operand registers shift right by one. The counter increments.
  - On the edge where the counter = WIDTH−1, the full result and the final borrow are copied into d and bout, and the next state is DONE.
- State DONE:
  - out_valid = 1.
  - d and bout hold stable.
  - On the edge where out_ready = 1, the next state is IDLE.
- d and bout change only on the copy edge at the end of SHIFT. Between operations they hold the last completed result.
- in_valid is ignored outside IDLE. Changes on a, b and bin after acceptance have no effect.
- No accept in the same cycle as a consume: after the consume edge, in_ready rises in the following cycle.
- rst asserted in any state, including mid-SHIFT or DONE with a pending result, forces all registers and outputs to their reset values on that edge. The in-flight operation is discarded.
- rst has priority over every handshake.

## Timing
- Acceptance edge T0: IDLE with in_valid = 1.
- Shift edges: T0+1 … T0+WIDTH.
- out_valid rises after edge T0+WIDTH, so latency is WIDTH cycles from acceptance.
- With out_ready tied high:
  - DONE lasts one cycle.
  - in_ready is high again after edge T0+WIDTH+1.
  - Sustained throughput is one operation per WIDTH+2 cycles, because the IDLE cycle is counted.
- out_valid stays high indefinitely under back-pressure (out_ready = 0). Nothing is lost.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Test plan
- Basic subtraction, WIDTH = 4: a = 9, b = 3, bin = 0, accepted at T0 → out_valid at T0+4 with d = 6, bout = 0, held for one cycle with out_ready = 1.
- Underflow: a = 3, b = 9, bin = 0 → d = 0xA, bout = 1. Then a = 0, b = 0, bin = 1 → d = 0xF, bout = 1. Then a = 15, b = 15, bin = 0 → d = 0, bout = 0.
- Back-pressure: out_ready = 0 for 10 cycles after completion of a = 12, b = 5 → out_valid, d = 7 and bout = 0 remain stable; in_ready stays 0. Raising out_ready → IDLE the next cycle.
- Busy-input immunity: in_valid held high while a, b and bin toggle randomly during SHIFT → the result matches only the operands latched at T0; the next acceptance happens only in IDLE.
- Reset mid-operation: rst pulsed at T0+2 → at the next edge out_valid = 0, d = 0, bout = 0, in_ready = 1. A new operation a = 8, b = 1 then completes correctly with d = 7.
- Exhaustive back-to-back run: all 512 combinations of a, b and bin with random out_ready stalls → d and bout match a − b − bin in every case, with no result dropped or duplicated.
